// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan controller: glyph table and blank code.
package sseg_pkg;

    // Segment order is {a,b,c,d,e,f,g}; a zero bit lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Host-side load/brightness inputs and display-side drive outputs of the scan controller.
interface sseg_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned PWM_BITS   = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic                      blank_lz;
    logic [PWM_BITS-1:0]       brightness;
    logic [6:0]                seg_n;
    logic                      dp_n;
    logic [NUM_DIGITS-1:0]     an_n;
    logic                      frame_done;

    // Host side: supplies the digits and brightness, observes the display drive.
    modport master (
        output load, value, dp_in, blank_lz, brightness,
        input  seg_n, dp_n, an_n, frame_done
    );

    // Controller side.
    modport slave (
        input  load, value, dp_in, blank_lz, brightness,
        output seg_n, dp_n, an_n, frame_done
    );
endinterface

// File: rtl/sseg_hex_decode.sv
// Nibble to active-low seven-segment glyph lookup (purely combinational).
module sseg_hex_decode
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n_c
);

    assign seg_n_c = GLYPH_TABLE[nibble];

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous updates,
// leading-zero suppression and PWM brightness.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned TICK_DIV   = 100000,
    parameter int unsigned PWM_BITS   = 4
) (
    input  logic               clk,
    input  logic               reset,
    sseg_scan_ctrl_if.slave    bus
);

    localparam int unsigned VAL_W  = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TICK_DIV - 1);

    // Reject illegal parameterisations at elaboration.
    if (NUM_DIGITS < 2 || NUM_DIGITS > 16) begin : g_bad_num_digits
        $error("sseg_scan_ctrl: NUM_DIGITS must be in 2..16");
    end
    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("sseg_scan_ctrl: TICK_DIV must be at least 2");
    end

    logic [TICK_W-1:0]     tick_cnt;
    logic [IDX_W-1:0]      digit_idx;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic                  frame_done_q;

    logic [VAL_W-1:0]      pend_value;
    logic [NUM_DIGITS-1:0] pend_dp;
    logic                  pend_blz;
    logic [VAL_W-1:0]      disp_value;
    logic [NUM_DIGITS-1:0] disp_dp;
    logic                  disp_blz;

    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] an_q;

    logic                  tick_c;
    logic                  wrap_c;
    logic [3:0]            nibble_c;
    logic [6:0]            glyph_c;
    logic [NUM_DIGITS-1:0] zero_from_c;
    logic                  blank_c;
    logic                  lit_c;
    logic [NUM_DIGITS-1:0] an_next_c;

    assign tick_c = (tick_cnt == LAST_TICK);
    assign wrap_c = tick_c && (digit_idx == LAST_IDX);

    // Slot timer, digit scanner, PWM phase and end-of-frame pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt     <= '0;
            digit_idx    <= '0;
            pwm_cnt      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            tick_cnt     <= tick_c ? '0 : tick_cnt + TICK_W'(1);
            if (tick_c) begin
                digit_idx <= wrap_c ? '0 : digit_idx + IDX_W'(1);
            end
            pwm_cnt      <= pwm_cnt + PWM_BITS'(1);
            frame_done_q <= wrap_c;
        end
    end

    // Pending capture on load; display refresh only at a frame wrap so a scan is never torn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_blz   <= 1'b0;
            disp_value <= '0;
            disp_dp    <= '0;
            disp_blz   <= 1'b0;
        end else begin
            if (bus.load) begin
                pend_value <= bus.value;
                pend_dp    <= bus.dp_in;
                pend_blz   <= bus.blank_lz;
            end
            if (wrap_c) begin
                // A load landing on the wrap edge bypasses pending straight to the display.
                if (bus.load) begin
                    disp_value <= bus.value;
                    disp_dp    <= bus.dp_in;
                    disp_blz   <= bus.blank_lz;
                end else begin
                    disp_value <= pend_value;
                    disp_dp    <= pend_dp;
                    disp_blz   <= pend_blz;
                end
            end
        end
    end

    // zero_from_c[i] is set when nibbles i..NUM_DIGITS-1 of the display value are all zero.
    always_comb begin
        logic run;
        zero_from_c = '0;
        run         = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run            = run && (disp_value[4*i +: 4] == 4'h0);
            zero_from_c[i] = run;
        end
    end

    assign nibble_c = disp_value[{digit_idx, 2'b00} +: 4];
    assign blank_c  = disp_blz && (digit_idx != '0) && zero_from_c[digit_idx];
    assign lit_c    = (pwm_cnt < bus.brightness);

    sseg_hex_decode u_hex_decode (
        .nibble  (nibble_c),
        .seg_n_c (glyph_c)
    );

    // One-cold anode for the current digit while the PWM phase is in its on-window.
    always_comb begin
        an_next_c = '1;
        if (lit_c && !blank_c) begin
            an_next_c[digit_idx] = 1'b0;
        end
    end

    // Registered display drive, one clock behind the scan state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q  <= '1;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_next_c;
            seg_q <= blank_c ? SEG_BLANK : glyph_c;
            dp_q  <= blank_c | ~disp_dp[digit_idx];
        end
    end

    assign bus.an_n       = an_q;
    assign bus.seg_n      = seg_q;
    assign bus.dp_n       = dp_q;
    assign bus.frame_done = frame_done_q;

endmodule
